// File: rtl/sink2_pkg.sv
// sink2_pkg: shared definitions for the toggle-handshake flit sink.
//   state_t       - sink FSM state encoding (IDLE/WAIT/HOLD, 2 bits)
//   FLIT_CNT_W    - width of the accepted-flit counter
//   FLIT_CNT_MAX  - saturation value of the accepted-flit counter
//   sat_inc()     - saturating increment for the flit counter
package sink2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int                    FLIT_CNT_W   = 8;
    localparam logic [FLIT_CNT_W-1:0] FLIT_CNT_MAX = 8'd255;

    // Saturating increment: the counter sticks at FLIT_CNT_MAX.
    function automatic logic [FLIT_CNT_W-1:0] sat_inc(input logic [FLIT_CNT_W-1:0] v);
        logic [FLIT_CNT_W-1:0] r;
        if (v == FLIT_CNT_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sink2_if.sv
// sink2_if: two-phase (toggle) req/ack flit channel between a source and a sink.
//   req  - toggles once per flit offered (source -> sink)
//   data - flit payload, stable from the req toggle until the matching ack toggle
//   ack  - toggles once per flit accepted (sink -> source)
// Modports: master = source side, slave = sink side.
interface sink2_if #(
    parameter int SIZE = 8
);
    logic            req;
    logic [SIZE-1:0] data;
    logic            ack;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/sink2_fifo.sv
// sink2_fifo: small synchronous FIFO with a registered head output.
//   clk, reset (async, active-low)
//   push/din  - write din when not full (or full with a same-cycle pop)
//   pop       - drop the head; ignored when empty
//   dout      - registered head; holds its last value while empty
//   empty/full- occupancy flags decoded from the count register
module sink2_fifo
    import sink2_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [SIZE-1:0] din,
    input  logic            pop,
    output logic [SIZE-1:0] dout,
    output logic            empty,
    output logic            full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [SIZE-1:0] mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [SIZE-1:0] dout_r;
    logic            pop_s;
    logic            push_s;
    logic [PW-1:0]   rd_next_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign pop_s     = pop & ~empty;
    assign push_s    = push & (~full | pop_s);
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    assign rd_next_s = rd_ptr_r + PW'(1);
    assign dout      = dout_r;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy count; push+pop together leaves the count alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered head: takes din when the FIFO is (or becomes) empty before
    // the push lands, otherwise the next stored entry after a pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r <= {SIZE{1'b0}};
        end else if (push_s && (empty || (pop_s && (count_r == CW'(1))))) begin
            dout_r <= din;
        end else if (pop_s && (count_r > CW'(1))) begin
            dout_r <= mem_r[rd_next_s];
        end else begin
            dout_r <= dout_r;
        end
    end

endmodule

// File: rtl/sink2.sv
// sink2: receiving end of the toggle req/ack flit handshake.
//   clk, reset (async, active-low)
//   flit        - sink2_if.slave: req/data in, ack out
//   out_data    - registered FIFO head, meaningful while out_valid=1
//   out_valid   - FIFO non-empty
//   out_ready   - consumer pops the head on out_valid & out_ready
//   flits       - accepted-flit count, saturating at 255
//   payload_err - sticky: an accepted flit differed from EXPECTED_PAYLOAD
//   proto_err   - sticky: req toggled while a flit was still unacknowledged
module sink2
    import sink2_pkg::*;
#(
    parameter int ID               = 0,
    parameter int SIZE             = 8,
    parameter int EXPECTED_PAYLOAD = 4,
    parameter bit CHECK_PAYLOAD    = 1'b1,
    parameter int ACK_DELAY        = 0,
    parameter int FIFO_DEPTH       = 4,
    parameter int SYNC_STAGES      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    sink2_if.slave                flit,
    output logic [SIZE-1:0]       out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLIT_CNT_W-1:0] flits,
    output logic                  payload_err,
    output logic                  proto_err
);

    localparam logic [3:0]      DELAY_LOAD = 4'(ACK_DELAY);
    localparam logic [SIZE-1:0] EXPECTED   = SIZE'(EXPECTED_PAYLOAD);

    // Reject configurations the delay counter and FIFO cannot represent.
    if (ID < 0 || ACK_DELAY < 0 || ACK_DELAY > 15 || SYNC_STAGES < 0 ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_params
        $error("sink2: illegal parameter set");
    end

    state_t                state_r;
    logic [3:0]            cnt_r;
    logic [SIZE-1:0]       hold_r;
    logic                  ack_r;
    logic [FLIT_CNT_W-1:0] flits_r;
    logic                  payload_err_r;
    logic                  proto_err_r;
    logic                  req_old_r;
    logic                  req_s;
    logic                  req_seen_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  pop_s;
    logic                  slot_s;
    logic                  push_s;

    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_r;

        // req synchronizer chain; the oldest stage feeds edge detection.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_r <= {SYNC_STAGES{1'b0}};
            end else begin
                sync_r <= (sync_r << 1) | SYNC_STAGES'(flit.req);
            end
        end

        assign req_s = sync_r[SYNC_STAGES-1];
    end else begin : g_nosync
        assign req_s = flit.req;
    end

    // Last seen req level; any difference marks a newly offered flit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_old_r <= 1'b0;
        end else begin
            req_old_r <= req_s;
        end
    end

    assign req_seen_s = req_s ^ req_old_r;
    assign out_valid  = ~fifo_empty_s;
    assign pop_s      = out_valid & out_ready;
    // A same-cycle pop frees the slot the push needs.
    assign slot_s     = ~fifo_full_s | pop_s;

    // Push decode: the held flit enters the FIFO once its delay has run out and a slot exists.
    always_comb begin
        push_s = 1'b0;
        case (state_r)
            ST_WAIT: push_s = (cnt_r == 4'd0) && slot_s;
            ST_HOLD: push_s = slot_s;
            default: push_s = 1'b0;
        endcase
    end

    // Handshake FSM with its registered ack, counter and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            hold_r        <= {SIZE{1'b0}};
            ack_r         <= 1'b0;
            flits_r       <= {FLIT_CNT_W{1'b0}};
            payload_err_r <= 1'b0;
            proto_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_seen_s) begin
                        hold_r  <= flit.data;
                        cnt_r   <= DELAY_LOAD;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else if (slot_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (slot_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase

            if (push_s) begin
                ack_r         <= ~ack_r;
                flits_r       <= sat_inc(flits_r);
                payload_err_r <= payload_err_r | (CHECK_PAYLOAD && (hold_r != EXPECTED));
            end

            // A toggle while busy is a source violation; the held flit is kept.
            if (req_seen_s && (state_r != ST_IDLE)) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    sink2_fifo #(
        .SIZE  (SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (hold_r),
        .pop   (pop_s),
        .dout  (out_data),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    assign flit.ack    = ack_r;
    assign flits       = flits_r;
    assign payload_err = payload_err_r;
    assign proto_err   = proto_err_r;

endmodule

// File: tb/tb_sink2.sv
// tb_sink2: two sink2 instances (default config, and depth-2 / delay-3 /
// 2-stage sync / no payload check) driven by toggle sources, compared every
// cycle against a transaction-level model, plus literal latency/reset checks.
module tb_sink2;

    localparam int         P_DEL   [2] = '{0, 3};
    localparam int         P_DEPTH [2] = '{4, 2};
    localparam int         P_SYNC  [2] = '{0, 2};
    localparam bit         P_CHK   [2] = '{1'b1, 1'b0};
    localparam logic [7:0] EXP_PAYLOAD = 8'd4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      req_d, rdy, ack_o, vld_o, perr_o, proto_o;
    logic [1:0][7:0] data_d, odata, flits_o;

    int n_pass  = 0;
    int n_total = 0;
    int tog [2];
    logic [1:0] prev_ack;
    bit d0_done, d1_done;

    sink2_if #(.SIZE(8)) fl0 ();
    sink2_if #(.SIZE(8)) fl1 ();
    assign fl0.req  = req_d[0];
    assign fl0.data = data_d[0];
    assign ack_o[0] = fl0.ack;
    assign fl1.req  = req_d[1];
    assign fl1.data = data_d[1];
    assign ack_o[1] = fl1.ack;

    sink2 #(.ID(0)) dut0 (
        .clk(clk), .reset(reset), .flit(fl0),
        .out_data(odata[0]), .out_valid(vld_o[0]), .out_ready(rdy[0]),
        .flits(flits_o[0]), .payload_err(perr_o[0]), .proto_err(proto_o[0])
    );

    sink2 #(.ID(1), .CHECK_PAYLOAD(1'b0), .ACK_DELAY(3), .FIFO_DEPTH(2), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .flit(fl1),
        .out_data(odata[1]), .out_valid(vld_o[1]), .out_ready(rdy[1]),
        .flits(flits_o[1]), .payload_err(perr_o[1]), .proto_err(proto_o[1])
    );

    // ---------------- behavioural model (transaction level) ----------------
    logic       m_req_old [2];
    logic [3:0] m_hist    [2];   // bit i: req sampled i+1 edges ago
    logic       m_busy    [2];
    logic [7:0] m_held    [2];
    int         m_ready   [2];   // first cycle the held flit may be queued
    int         m_cyc     [2];
    logic [7:0] m_fifo    [2][16];
    int         m_n       [2];
    logic [7:0] m_head    [2];
    int         m_acks    [2];
    logic       m_perr    [2];
    logic       m_proto   [2];

    task automatic mreset(input int k);
        m_req_old[k] = 1'b0; m_hist[k] = 4'd0; m_busy[k] = 1'b0; m_held[k] = 8'd0;
        m_ready[k] = 0; m_cyc[k] = 0; m_n[k] = 0; m_head[k] = 8'd0;
        m_acks[k] = 0; m_perr[k] = 1'b0; m_proto[k] = 1'b0;
    endtask

    task automatic mstep(input int k);
        logic rs, pop, slot, push;
        logic [7:0] pv;
        rs   = (P_SYNC[k] == 0) ? req_d[k] : m_hist[k][P_SYNC[k]-1];
        pop  = (m_n[k] > 0) && rdy[k];
        slot = (m_n[k] < P_DEPTH[k]) || pop;
        push = 1'b0;
        pv   = 8'd0;
        if (m_busy[k]) begin
            if (rs != m_req_old[k]) m_proto[k] = 1'b1;
            if (m_cyc[k] >= m_ready[k] && slot) begin
                push = 1'b1; pv = m_held[k]; m_busy[k] = 1'b0;
            end
        end else if (rs != m_req_old[k]) begin
            m_held[k]  = data_d[k];
            m_busy[k]  = 1'b1;
            m_ready[k] = m_cyc[k] + 1 + P_DEL[k];
        end
        if (pop) begin
            for (int i = 0; i < 15; i++) m_fifo[k][i] = m_fifo[k][i+1];
            m_n[k]--;
        end
        if (push) begin
            m_fifo[k][m_n[k]] = pv;
            m_n[k]++;
            m_acks[k]++;
            if (P_CHK[k] && pv != EXP_PAYLOAD) m_perr[k] = 1'b1;
        end
        if (m_n[k] > 0) m_head[k] = m_fifo[k][0];
        m_req_old[k] = rs;
        m_hist[k]    = {m_hist[k][2:0], req_d[k]};
        m_cyc[k]++;
    endtask

    initial begin
        mreset(0);
        mreset(1);
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mreset(0);
                mreset(1);
            end else begin
                mstep(0);
                mstep(1);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, k, act, exp, $time);
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        tog[0] = 0; tog[1] = 0; prev_ack = 2'b00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                tog[0] = 0; tog[1] = 0; prev_ack = 2'b00;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (ack_o[k] !== prev_ack[k]) tog[k]++;
                    prev_ack[k] = ack_o[k];
                    chk("ack", k, ack_o[k], m_acks[k][0]);
                    chk("out_valid", k, vld_o[k], (m_n[k] > 0));
                    if (m_n[k] > 0) chk("out_data", k, odata[k], m_head[k]);
                    chk("flits", k, flits_o[k], (m_acks[k] > 255) ? 255 : m_acks[k]);
                    chk("payload_err", k, perr_o[k], m_perr[k]);
                    chk("proto_err", k, proto_o[k], m_proto[k]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (ack_o[k] !== req_d[k] && n < 400) begin tick(1); n++; end
        if (n >= 400) begin
            n_total++;
            $display("FAIL ack_timeout dut%0d: ack %0b still differs from req %0b", k, ack_o[k], req_d[k]);
        end
    endtask

    task automatic send(input int k, input logic [7:0] d);
        wait_idle(k);
        data_d[k] = d;
        req_d[k]  = ~req_d[k];
    endtask

    task automatic chk_reset_vals();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack", k, ack_o[k], 0);
            chk("rst_valid", k, vld_o[k], 0);
            chk("rst_flits", k, flits_o[k], 0);
            chk("rst_perr", k, perr_o[k], 0);
            chk("rst_proto", k, proto_o[k], 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        req_d = 2'b00; rdy = 2'b00; data_d = '0;
        tick(3);
        chk_reset_vals();
        chk("rst_data", 0, odata[0], 0);
        #2 reset = 1'b1;
        tick(1);

        // DUT0 latency: capture one edge after the toggle, ack one edge later.
        rdy[0] = 1'b1;
        send(0, 8'd4);
        tick(1);
        chk("lat_e1_ack", 0, ack_o[0], 0);
        tick(1);
        chk("lat_e2_ack", 0, ack_o[0], 1);
        chk("lat_e2_valid", 0, vld_o[0], 1);
        chk("lat_e2_data", 0, odata[0], 4);
        tick(1);
        chk("one_cycle_valid", 0, vld_o[0], 0);
        send(0, 8'd4);
        tick(2);
        chk("second_ack", 0, ack_o[0], 0);
        chk("second_data", 0, odata[0], 4);
        wait_idle(0);
        tick(2);
        chk("two_flits", 0, flits_o[0], 2);
        chk("two_flits_perr", 0, perr_o[0], 0);
        chk("two_toggles", 0, tog[0], 2);

        // Wrong payload: flagged on the checking sink only, sticky.
        rdy[1] = 1'b1;
        send(0, 8'd5);
        send(1, 8'd5);
        wait_idle(0);
        wait_idle(1);
        tick(2);
        chk("bad_payload_err", 0, perr_o[0], 1);
        chk("nocheck_err", 1, perr_o[1], 0);
        chk("bad_payload_acked", 0, flits_o[0], 3);
        send(0, 8'd4);
        wait_idle(0);
        tick(2);
        chk("perr_sticky", 0, perr_o[0], 1);
        chk("nocheck_flits", 1, flits_o[1], 1);

        // Saturation on DUT0 alongside random traffic on DUT1.
        base = tog[0];
        d0_done = 1'b0;
        d1_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 260; i++) begin
                    send(0, 8'd4);
                    repeat ($urandom_range(0, 2)) tick(1);
                end
                wait_idle(0);
                d0_done = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    send(1, 8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 3)) tick(1);
                end
                wait_idle(1);
                d1_done = 1'b1;
            end
            begin
                while (!(d0_done && d1_done)) begin
                    rdy[0] = 1'($urandom_range(0, 1));
                    rdy[1] = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        rdy = 2'b11;
        tick(4);
        chk("sat_flits", 0, flits_o[0], 255);
        chk("sat_acks", 0, tog[0] - base, 260);

        // DUT1: 2 sync stages + 3 delay cycles put the ack 7 edges after the toggle.
        wait_idle(1);
        tick(3);
        base = tog[1];
        send(1, 8'd4);
        tick(6);
        chk("delay_early", 1, tog[1] - base, 0);
        tick(1);
        chk("delay_ack", 1, tog[1] - base, 1);
        chk("delay_valid", 1, vld_o[1], 1);
        chk("delay_data", 1, odata[1], 4);

        // Toggle again while the flit is in its delay window.
        base = tog[1];
        send(1, 8'd9);
        tick(1);
        req_d[1] = ~req_d[1];
        tick(12);
        chk("proto_no_extra_ack", 1, tog[1] - base, 1);
        chk("proto_flag", 1, proto_o[1], 1);

        // Fresh start, then fill DUT1 (depth 2) with out_ready low.
        reset = 1'b0; req_d = 2'b00; rdy = 2'b00; data_d = '0;
        tick(2);
        reset = 1'b1;
        send(1, 8'd1);
        send(1, 8'd2);
        send(1, 8'd3);
        tick(15);
        chk("full_two_acks", 1, tog[1], 2);
        chk("full_valid", 1, vld_o[1], 1);
        chk("full_head", 1, odata[1], 1);
        rdy[1] = 1'b1;
        tick(1);
        rdy[1] = 1'b0;
        chk("pop_third_ack", 1, tog[1], 3);
        chk("pop_head", 1, odata[1], 2);
        send(1, 8'd4);
        tick(15);
        chk("hold_no_ack", 1, tog[1], 3);

        // Asynchronous reset mid-HOLD with two entries queued.
        #2 reset = 1'b0;
        req_d = 2'b00; rdy = 2'b00;
        #1;
        chk_reset_vals();
        tick(2);
        reset = 1'b1;
        rdy[1] = 1'b1;
        send(1, 8'd4);
        tick(6);
        chk("post_rst_early", 1, tog[1], 0);
        tick(1);
        chk("post_rst_ack", 1, tog[1], 1);
        chk("post_rst_flits", 1, flits_o[1], 1);
        chk("post_rst_data", 1, odata[1], 4);
        chk("post_rst_proto", 1, proto_o[1], 0);

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
